conv_apb_master: RTL and testbench

APB initiator that issues single register transfers from a simple valid/ready request port to the convolution accelerator's APB register file. It sits between the host-side control sequencer and the accelerator's APB slave port. It drives the PADDR/PSEL/PENABLE/PWRITE/PWDATA bus and returns PRDATA/PSLVERR through a valid/ready response port. Typical traffic: writing flen/in_ch/out_ch/command, then reading the done and clock-counter registers.

---
 rtl/conv_apb_master.sv | 163 ++++++++++++++++
 tb/tb_conv_apb_master.sv | 386 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_apb_master.sv
// Single-transfer APB initiator between a valid/ready request/response port and the conv accelerator register file.
// Optional PREADY watchdog is enabled by defining CONV_APB_TIMEOUT_EN.
//
// state  | meaning
// IDLE   | waiting for a request, req_ready=1
// SETUP  | APB setup phase, PSEL=1 PENABLE=0, always one cycle
// ACCESS | APB access phase, PSEL=1 PENABLE=1, waits for PREADY (or watchdog)
// RESP   | response presented on rsp_*, waits for rsp_ready
module conv_apb_master #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  CLK,
    input  logic                  RESETN,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  rsp_timeout,
    output logic [ADDR_WIDTH-1:0] PADDR,
    output logic                  PSEL,
    output logic                  PENABLE,
    output logic                  PWRITE,
    output logic [DATA_WIDTH-1:0] PWDATA,
    input  logic [DATA_WIDTH-1:0] PRDATA,
    input  logic                  PREADY,
    input  logic                  PSLVERR
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    state_t state;
    state_t state_nxt;

    logic                  accept;
    logic                  timed_out;
    logic [ADDR_WIDTH-1:0] paddr_q;
    logic                  pwrite_q;
    logic [DATA_WIDTH-1:0] pwdata_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  err_q;

    assign accept = (state == ST_IDLE) && req_valid;

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        req_ready = 1'b0;
        PSEL      = 1'b0;
        PENABLE   = 1'b0;
        rsp_valid = 1'b0;
        case (state)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_nxt = ST_SETUP;
            end
            ST_SETUP: begin
                PSEL      = 1'b1;
                state_nxt = ST_ACCESS;
            end
            ST_ACCESS: begin
                PSEL    = 1'b1;
                PENABLE = 1'b1;
                if (PREADY || timed_out) state_nxt = ST_RESP;
            end
            ST_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Bus fields are latched once per transfer; a read zeroes PWDATA so stale write data never lingers.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            paddr_q  <= '0;
            pwrite_q <= 1'b0;
            pwdata_q <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else if (accept) begin
            paddr_q  <= req_addr;
            pwrite_q <= req_write;
            pwdata_q <= req_write ? req_wdata : '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else if (state == ST_ACCESS) begin
            if (PREADY) begin
                if (!pwrite_q) rdata_q <= PRDATA;
                err_q <= PSLVERR;
            end else if (timed_out) begin
                err_q <= 1'b1;
            end
        end
    end

    assign PADDR     = paddr_q;
    assign PWRITE    = pwrite_q;
    assign PWDATA    = pwdata_q;
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

    // The watchdog parameter is meaningless below 1; nothing extra is built in that case.
    if (TIMEOUT_CYCLES < 1) begin : g_timeout_range
    end

`ifdef CONV_APB_TIMEOUT_EN
    localparam int RAW_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int CNT_W = (RAW_W < 8) ? 8 : ((RAW_W > 32) ? 32 : RAW_W);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] wait_cnt;
    logic             timeout_q;

    // wait_cnt holds the number of earlier stalled ACCESS cycles; PREADY wins on the limit cycle.
    assign timed_out = (state == ST_ACCESS) && !PREADY && (wait_cnt == LIMIT);

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            wait_cnt <= '0;
        end else if (state == ST_SETUP) begin
            wait_cnt <= '0;
        end else if ((state == ST_ACCESS) && !PREADY) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            timeout_q <= 1'b0;
        end else if (accept) begin
            timeout_q <= 1'b0;
        end else if (timed_out) begin
            timeout_q <= 1'b1;
        end
    end

    assign rsp_timeout = timeout_q;
`else
    assign timed_out   = 1'b0;
    assign rsp_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_conv_apb_master.sv
// Self-checking bench for conv_apb_master: transaction-level model with per-cycle compare.
// Builds with or without CONV_APB_TIMEOUT_EN; the watchdog scenario adapts to the build.
module tb_conv_apb_master;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 4;
`ifdef CONV_APB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic          CLK = 1'b0;
    logic          RESETN = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_write = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] req_wdata = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic          rsp_timeout;
    logic [AW-1:0] PADDR;
    logic          PSEL;
    logic          PENABLE;
    logic          PWRITE;
    logic [DW-1:0] PWDATA;
    logic [DW-1:0] PRDATA = '0;
    logic          PREADY = 1'b0;
    logic          PSLVERR = 1'b0;

    conv_apb_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
        .CLK(CLK), .RESETN(RESETN),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
        .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PWDATA(PWDATA),
        .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Transaction model: t counts cycles since the accepting edge (t=1 is the setup cycle).
    bit            m_busy = 1'b0;
    int            t = 0;
    int            acc_len = 0;
    bit            m_to = 1'b0;
    logic [AW-1:0] m_addr = '0;
    bit            m_write = 1'b0;
    logic [DW-1:0] m_wdata = '0;
    logic [DW-1:0] m_prdata = '0;
    bit            m_perr = 1'b0;
    logic [DW-1:0] e_rdata = '0;
    bit            e_err = 1'b0;
    bit            e_to = 1'b0;
    logic [AW-1:0] e_paddr = '0;
    bit            e_pwrite = 1'b0;
    logic [DW-1:0] e_pwdata = '0;

    // Stimulus controls
    bit            rand_mode = 1'b0;
    bit            always_valid = 1'b0;
    int            max_waits = 0;
    bit            rsp_rand = 1'b0;
    int            rsp_hold_left = 0;
    bit            want_req = 1'b0;
    bit            nx_write = 1'b0;
    logic [AW-1:0] nx_addr = '0;
    logic [DW-1:0] nx_wdata = '0;
    int            nx_waits = 0;
    logic [DW-1:0] nx_rdata = '0;
    bit            nx_err = 1'b0;
    bit            b2b_chk = 1'b0;
    int            last_acc = -1;
    int            n_acc = 0;

    // Observations for hand-computed checks
    int            lat_obs = 0;
    int            psel_cnt = 0;
    int            pen_cnt = 0;
    logic [DW-1:0] obs_rdata = '0;
    logic          obs_err = 1'b0;
    logic          obs_to = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d, t=%0d)", name, act, exp, cyc, t);
        end
    endtask

    function automatic bit in_xfer();
        return m_busy && (t >= 1) && (t <= 1 + acc_len);
    endfunction

    function automatic bit in_rsp();
        return m_busy && (t >= 2 + acc_len);
    endfunction

    task automatic drive();
        if (!m_busy) begin
            if (rand_mode) begin
                req_valid = always_valid ? 1'b1 : ($urandom_range(0, 3) != 0);
                req_write = 1'($urandom_range(0, 1));
                req_addr  = $urandom;
                req_wdata = $urandom;
                nx_waits  = $urandom_range(0, max_waits);
                nx_rdata  = $urandom;
                nx_err    = ($urandom_range(0, 4) == 0);
            end else begin
                req_valid = want_req;
                req_write = want_req ? nx_write : 1'($urandom_range(0, 1));
                req_addr  = want_req ? nx_addr : $urandom;
                req_wdata = want_req ? nx_wdata : $urandom;
            end
        end else begin
            req_valid = 1'($urandom_range(0, 1));
            req_write = 1'($urandom_range(0, 1));
            req_addr  = $urandom;
            req_wdata = $urandom;
        end
        if (m_busy && t >= 2 && t <= 1 + acc_len) begin
            PREADY  = (t == 1 + acc_len) && !m_to;
            PRDATA  = PREADY ? m_prdata : $urandom;
            PSLVERR = PREADY ? m_perr : 1'($urandom_range(0, 1));
        end else begin
            PREADY  = 1'($urandom_range(0, 1));
            PRDATA  = $urandom;
            PSLVERR = 1'($urandom_range(0, 1));
        end
        if (in_rsp()) rsp_ready = rsp_rand ? 1'($urandom_range(0, 1)) : (rsp_hold_left == 0);
        else          rsp_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic check();
        chk("req_ready", req_ready, !m_busy);
        chk("psel", PSEL, in_xfer());
        chk("penable", PENABLE, in_xfer() && t >= 2);
        chk("rsp_valid", rsp_valid, in_rsp());
        chk("paddr", PADDR, e_paddr);
        chk("pwrite", PWRITE, e_pwrite);
        if (!in_xfer())   chk("pwdata_hold", PWDATA, e_pwdata);
        else if (m_write) chk("pwdata_xfer", PWDATA, m_wdata);
        chk("rsp_rdata", rsp_rdata, e_rdata);
        chk("rsp_err", rsp_err, e_err);
        chk("rsp_timeout", rsp_timeout, e_to);
        if (m_busy) begin
            if (PSEL) psel_cnt++;
            if (PENABLE) pen_cnt++;
            if (rsp_valid && lat_obs == 0) begin
                lat_obs   = t;
                obs_rdata = rsp_rdata;
                obs_err   = rsp_err;
                obs_to    = rsp_timeout;
            end
        end
    endtask

    task automatic update();
        cyc++;
        if (!m_busy) begin
            if (req_valid) begin
                m_busy   = 1'b1;
                t        = 1;
                m_addr   = req_addr;
                m_write  = req_write;
                m_wdata  = req_wdata;
                e_paddr  = req_addr;
                e_pwrite = req_write;
                e_pwdata = req_write ? req_wdata : '0;
                e_rdata  = '0;
                e_err    = 1'b0;
                e_to     = 1'b0;
                m_prdata = nx_rdata;
                m_perr   = nx_err;
                if (TO_EN && nx_waits >= TO) begin
                    acc_len = TO;
                    m_to    = 1'b1;
                end else begin
                    acc_len = nx_waits + 1;
                    m_to    = 1'b0;
                end
                lat_obs  = 0;
                psel_cnt = 0;
                pen_cnt  = 0;
                n_acc++;
                if (b2b_chk && last_acc >= 0) chk("b2b_spacing", cyc - last_acc, 4);
                last_acc = cyc;
            end
        end else if (in_rsp() && rsp_ready) begin
            m_busy = 1'b0;
        end else begin
            if (in_rsp() && !rsp_rand && rsp_hold_left > 0) rsp_hold_left--;
            t++;
            if (t == 2 + acc_len) begin
                e_rdata = (m_to || m_write) ? '0 : m_prdata;
                e_err   = m_to ? 1'b1 : m_perr;
                e_to    = m_to;
            end
        end
    endtask

    task automatic step();
        @(negedge CLK);
        check();
        @(posedge CLK);
        #1;
        update();
        drive();
    endtask

    task automatic model_reset();
        m_busy   = 1'b0;
        t        = 0;
        e_rdata  = '0;
        e_err    = 1'b0;
        e_to     = 1'b0;
        e_paddr  = '0;
        e_pwrite = 1'b0;
        e_pwdata = '0;
    endtask

    task automatic async_reset();
        @(negedge CLK);
        #2;
        RESETN = 1'b0;
        #1;
        chk("rst_psel", PSEL, 1'b0);
        chk("rst_penable", PENABLE, 1'b0);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_req_ready", req_ready, 1'b1);
        chk("rst_paddr", PADDR, 32'h0);
        model_reset();
        want_req = 1'b0;
        @(posedge CLK);
        #1;
        RESETN = 1'b1;
        drive();
    endtask

    task automatic issue(input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input int waits, input logic [DW-1:0] rd, input bit e, input int hold);
        int budget;
        nx_write = w; nx_addr = a; nx_wdata = d; nx_waits = waits;
        nx_rdata = rd; nx_err = e; rsp_hold_left = hold; want_req = 1'b1;
        drive();
        budget = 0;
        while (!m_busy && budget < 20) begin
            step();
            budget++;
        end
        want_req = 1'b0;
        if (!m_busy) begin
            checks++; errors++;
            $display("FAIL accept_timeout: request not accepted within %0d cycles", budget);
        end
    endtask

    task automatic finish_xfer(input int limit);
        int budget;
        budget = 0;
        while (m_busy && budget < limit) begin
            step();
            budget++;
        end
        if (m_busy) begin
            checks++; errors++;
            $display("FAIL xfer_done: transfer still open after %0d cycles", budget);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int budget;
        rsp_rand = 1'b0;
        #1;
        chk("reset_req_ready", req_ready, 1'b1);
        chk("reset_psel", PSEL, 1'b0);
        chk("reset_penable", PENABLE, 1'b0);
        chk("reset_rsp_valid", rsp_valid, 1'b0);
        chk("reset_paddr", PADDR, 32'h0);
        chk("reset_pwdata", PWDATA, 32'h0);
        chk("reset_rsp_err", rsp_err, 1'b0);
        @(posedge CLK);
        @(posedge CLK);
        #1;
        RESETN = 1'b1;
        drive();

        // zero-wait write
        issue(1'b1, 32'h0000_0000, 32'h0000_0105, 0, 32'h0, 1'b0, 0);
        finish_xfer(50);
        chk("w0_latency", lat_obs, 3);
        chk("w0_psel_cycles", psel_cnt, 2);
        chk("w0_penable_cycles", pen_cnt, 1);
        chk("w0_rdata", obs_rdata, 32'h0);
        chk("w0_err", obs_err, 1'b0);
        chk("w0_pwdata_after", PWDATA, 32'h0000_0105);

        // read with three wait states (also the PREADY-wins boundary when the watchdog is on)
        issue(1'b0, 32'h0000_0010, 32'h1234_5678, 3, 32'hDEAD_BEEF, 1'b0, 0);
        finish_xfer(50);
        chk("r3_latency", lat_obs, 6);
        chk("r3_rdata", obs_rdata, 32'hDEAD_BEEF);
        chk("r3_timeout", obs_to, 1'b0);
        chk("r3_pwdata_after", PWDATA, 32'h0);

        // slave error, response held for 5 cycles
        issue(1'b0, 32'h0000_0020, 32'h0, 1, 32'h0BAD_0BAD, 1'b1, 5);
        finish_xfer(50);
        chk("err_flag", obs_err, 1'b1);
        chk("err_timeout", obs_to, 1'b0);
        chk("err_latency", lat_obs, 4);

        // watchdog: PREADY never returns
        issue(1'b0, 32'h0000_0030, 32'h0, 100000, 32'hFFFF_FFFF, 1'b0, 0);
        if (TO_EN) begin
            finish_xfer(50);
            chk("to_latency", lat_obs, 6);
            chk("to_access_cycles", pen_cnt, 4);
            chk("to_err", obs_err, 1'b1);
            chk("to_flag", obs_to, 1'b1);
            chk("to_rdata", obs_rdata, 32'h0);
        end else begin
            for (int i = 0; i < 1000; i++) step();
            chk("hang_psel", PSEL, 1'b1);
            chk("hang_penable", PENABLE, 1'b1);
            chk("hang_rsp_valid", rsp_valid, 1'b0);
            async_reset();
        end

        // asynchronous reset in the middle of an ACCESS phase
        nx_write = 1'b1; nx_addr = 32'h0000_0040; nx_wdata = 32'h0000_0007; nx_waits = 10;
        nx_rdata = 32'h0; nx_err = 1'b0; rsp_hold_left = 0; want_req = 1'b1;
        drive();
        budget = 0;
        while (!(m_busy && t == 3) && budget < 20) begin
            step();
            budget++;
            if (m_busy) want_req = 1'b0;
        end
        chk("pre_reset_penable", PENABLE, 1'b1);
        async_reset();
        issue(1'b1, 32'h0000_0044, 32'h0000_0003, 0, 32'h0, 1'b0, 0);
        finish_xfer(50);
        chk("post_reset_latency", lat_obs, 3);
        chk("post_reset_paddr", PADDR, 32'h0000_0044);

        // back-to-back random requests, zero wait states
        rand_mode = 1'b1; always_valid = 1'b1; max_waits = 0; rsp_hold_left = 0;
        b2b_chk = 1'b1; last_acc = -1; n_acc = 0;
        drive();
        budget = 0;
        while (n_acc < 10 && budget < 200) begin
            step();
            budget++;
        end
        rand_mode = 1'b0; always_valid = 1'b0; b2b_chk = 1'b0;
        finish_xfer(50);
        chk("b2b_count", n_acc, 10);

        // random traffic: gaps, wait states, slave errors, response backpressure
        rand_mode = 1'b1; max_waits = TO_EN ? 6 : 5; rsp_rand = 1'b1;
        drive();
        for (int i = 0; i < 3000; i++) step();
        rand_mode = 1'b0; rsp_rand = 1'b0; rsp_hold_left = 0;
        finish_xfer(200);
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
